// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit unsigned adder. One full-adder slice plus a carry
// flip-flop adds two captured operands LSB-first, one bit per clock. Each sum
// bit is streamed while it is produced; the parallel sum and carry-out are
// registered at the last bit and flagged with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   ip1, ip2   addends, captured on the accepting edge
//   busy       high while the addition is running
//   sum_valid  qualifies sum_bit (same as busy)
//   sum_bit    current sum bit, LSB first; 0 outside RUN
//   done       one-cycle pulse after the last bit; sum/carry valid
//   sum        parallel result, (ip1 + ip2) mod 2^WIDTH, held until next done
//   carry      carry-out of bit WIDTH-1, held until next done
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  output logic             busy,
  output logic             sum_valid,
  output logic             sum_bit,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full-adder slice on the current operand LSBs and the stored carry.
  logic slice_sum;
  logic slice_carry;
  assign slice_sum   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign slice_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

  // The oldest sum bit falls off the end of the shift register on every
  // shift; the completed result is taken from the shifted-in value instead.
  logic s_sh_unused;
  assign s_sh_unused = s_sh_q[0];

  // Next-state and datapath logic.
  // NOTE: every signal assigned here gets a hold value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // sum/carry deliberately untouched: they keep the previous result.
          a_sh_d  = ip1;
          b_sh_d  = ip2;
          s_sh_d  = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = {slice_sum, s_sh_q[WIDTH-1:1]};
        c_d    = slice_carry;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          sum_d   = {slice_sum, s_sh_q[WIDTH-1:1]};
          carry_d = slice_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Every register is cleared so a mid-run reset discards
  // the partial result and the held sum/carry alike.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output
  // combinationally.
  assign busy      = (state_q == RUN);
  assign sum_valid = (state_q == RUN);
  assign sum_bit   = (state_q == RUN) & slice_sum;
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Scoreboard bench for serial_adder. Drivers push hand-computed expected sum
// bits and results into queues; monitors pop and compare whenever the DUTs
// present sum_valid or done. An 8-bit instance covers the directed vectors
// and a 2-bit instance covers all 16 operand pairs.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  // 8-bit instance
  logic       start;
  logic [7:0] ip1, ip2;
  logic       busy, sum_valid, sum_bit, done, carry;
  logic [7:0] sum;

  // 2-bit instance
  logic       start2;
  logic [1:0] ip1_2, ip2_2;
  logic       busy2, sum_valid2, sum_bit2, done2, carry2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

  logic       bit_q[$];
  logic [8:0] res_q[$];    // {carry, sum}
  logic [2:0] res2_q[$];   // {carry, sum}

  logic [7:0] last_sum   = 8'h00;
  logic       last_carry = 1'b0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ip1       (ip1),
    .ip2       (ip2),
    .busy      (busy),
    .sum_valid (sum_valid),
    .sum_bit   (sum_bit),
    .done      (done),
    .sum       (sum),
    .carry     (carry)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .ip1       (ip1_2),
    .ip2       (ip2_2),
    .busy      (busy2),
    .sum_valid (sum_valid2),
    .sum_bit   (sum_bit2),
    .done      (done2),
    .sum       (sum2),
    .carry     (carry2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output presented with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor for the 8-bit instance, sampling on the falling edge.
  initial begin
    int  run_len   = 0;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len   = 0;
        prev_done = 1'b0;
      end else begin
        check("busy_eq_sum_valid", busy, sum_valid);
        if (sum_valid) begin
          if (bit_q.size() == 0) flag("sum_bit_unexpected");
          else check("sum_bit", sum_bit, bit_q.pop_front());
        end else begin
          check("sum_bit_idle_zero", sum_bit, 0);
        end
        if (done) begin
          check("done_back_to_back", prev_done, 0);
          if (res_q.size() == 0) flag("done_unexpected");
          else check("result", {carry, sum}, res_q.pop_front());
        end
        if (busy) begin
          run_len++;
        end else if (run_len != 0) begin
          check("busy_length", run_len, 8);
          run_len = 0;
        end
        prev_done = done;
      end
    end
  end

  // Monitor for the 2-bit instance.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done2) begin
        if (res2_q.size() == 0) flag("w2_done_unexpected");
        else check("w2_result", {carry2, sum2}, res2_q.pop_front());
      end
    end
  end

  task automatic expect_op(input logic [7:0] es, input logic ec);
    for (int k = 0; k < 8; k++) bit_q.push_back(es[k]);
    res_q.push_back({ec, es});
  endtask

  // Issue one addition on the 8-bit DUT; caller is 1 time unit after a
  // rising edge with the DUT idle. With disturb set, start is pulsed and the
  // operands change to 0xAA mid-run.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec, input bit disturb);
    int n;
    expect_op(es, ec);
    start = 1'b1;
    ip1   = a;
    ip2   = b;
    @(posedge clk); #1;                       // accepting edge E0
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("sum_hold_on_start", sum, last_sum);
    check("carry_hold_on_start", carry, last_carry);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 2) begin
        start = 1'b1;
        ip1   = 8'hAA;
        ip2   = 8'hAA;
      end
      if (disturb && n == 3) start = 1'b0;
    end while (!done && n < 40);
    check("done_latency_edges", n, 8);
    last_sum   = es;
    last_carry = ec;
    @(posedge clk); #1;
    check("idle_after_done_busy", busy, 0);
    check("idle_after_done_done", done, 0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    ip1    = 8'h00;
    ip2    = 8'h00;
    ip1_2  = 2'd0;
    ip2_2  = 2'd0;

    #20;
    check("reset_busy", busy, 0);
    check("reset_sum_valid", sum_valid, 0);
    check("reset_sum_bit", sum_bit, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_carry", carry, 0);
    check("reset_w2_outputs", {busy2, done2, sum2, carry2}, 0);
    #2 rst_n = 1'b1;                          // away from the edge at 25
    @(posedge clk); #1;

    // Basic vector and carry propagation.
    run_op(8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);

    // start held high: accept at E0, done after E0+8, re-accept at E0+10.
    expect_op(8'h03, 1'b0);
    expect_op(8'h03, 1'b0);
    start = 1'b1;
    ip1   = 8'h01;
    ip2   = 8'h02;
    @(posedge clk); #1;                       // E0
    check("held_busy_e0", busy, 1);
    repeat (7) @(posedge clk);
    #1;                                       // E0+7
    check("held_busy_e7", busy, 1);
    @(posedge clk); #1;                       // E0+8
    check("held_done_e8", done, 1);
    @(posedge clk); #1;                       // E0+9
    check("held_idle_e9_busy", busy, 0);
    check("held_idle_e9_done", done, 0);
    @(posedge clk); #1;                       // E0+10
    check("held_reaccept_e10", busy, 1);
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    check("held_second_latency", n, 8);
    last_sum   = 8'h03;
    last_carry = 1'b0;
    @(posedge clk); #1;

    // Operand change and start pulse during RUN must not disturb the result.
    run_op(8'h33, 8'h44, 8'h77, 1'b0, 1'b1);

    // Reset during bit 4 of 0x80+0x80: only bits 0..3 are ever presented.
    for (int k = 0; k < 4; k++) bit_q.push_back(1'b0);
    start = 1'b1;
    ip1   = 8'h80;
    ip2   = 8'h80;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;                                       // bit 4 now on the output
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_sum_valid", sum_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_carry", carry, 0);
    check("midrst_sum_bit", sum_bit, 0);
    last_sum   = 8'h00;
    last_carry = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_done", done, 0);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);

    // 2-bit instance: all operand pairs, done two edges after each accept.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        res2_q.push_back(3'(a + b));
        start2 = 1'b1;
        ip1_2  = 2'(a);
        ip2_2  = 2'(b);
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!done2 && n < 20);
        check("w2_latency_edges", n, 2);
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("bit_queue_drained", bit_q.size(), 0);
    check("result_queue_drained", res_q.size(), 0);
    check("w2_queue_drained", res2_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
